// File: rtl/i2s_pkg.sv
// Shared constants and derivation helpers for the I2S/TDM transceiver.
// Latency: n/a (compile-time only).
// Backpressure: n/a.
package i2s_pkg;

  // Serial format selection
  localparam int unsigned MODE_I2S = 0;  // data delayed one sclk after ws edge
  localparam int unsigned MODE_LJ  = 1;  // data aligned to ws edge

  // Number of sclk periods in one full frame
  function automatic int unsigned frame_len(input int unsigned n_ch,
                                            input int unsigned slot_width);
    return n_ch * slot_width;
  endfunction

  // Bit delay between slot start and the MSB of that slot's sample
  function automatic int unsigned data_dly(input int unsigned mode);
    return (mode == MODE_I2S) ? 1 : 0;
  endfunction

endpackage

// File: rtl/i2s_clk_gen.sv
// Bit-clock, frame-sync and bit-position generator derived from mclk.
// Latency: strobes are combinational and flag the cycle whose closing edge makes the event.
// Backpressure: none; free-running once reset is released.
//
// Ports:
//   mclk, reset_n     : master clock, async active-low reset
//   sclk, ws          : serial bit clock and word select (both derived from counter flops)
//   sclk_fall         : this cycle's closing edge drops sclk and advances bit_cnt
//   sclk_rise         : this cycle's closing edge raises sclk (receive sample point)
//   fb                : frame boundary, this cycle's closing edge wraps bit_cnt to 0
//   bit_cnt           : current bit position inside the frame
//   bit_cnt_nxt       : bit position that becomes current on the closing edge
module i2s_clk_gen
  import i2s_pkg::*;
#(
  parameter int unsigned SLOT_WIDTH      = 32,
  parameter int unsigned N_CH            = 2,
  parameter int unsigned MCLK_SCLK_RATIO = 4
) (
  input  logic                                mclk,
  input  logic                                reset_n,
  output logic                                sclk,
  output logic                                ws,
  output logic                                sclk_fall,
  output logic                                sclk_rise,
  output logic                                fb,
  output logic [$clog2(N_CH*SLOT_WIDTH)-1:0]  bit_cnt,
  output logic [$clog2(N_CH*SLOT_WIDTH)-1:0]  bit_cnt_nxt
);

  localparam int unsigned FRAME = frame_len(N_CH, SLOT_WIDTH);
  localparam int unsigned BCW   = $clog2(FRAME);
  localparam int unsigned MCW   = $clog2(MCLK_SCLK_RATIO);

  localparam logic [MCW-1:0] MC_LAST  = MCW'(MCLK_SCLK_RATIO - 1);
  localparam logic [MCW-1:0] MC_HALF  = MCW'(MCLK_SCLK_RATIO / 2);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(FRAME - 1);
  localparam logic [BCW-1:0] BIT_HALF = BCW'(FRAME / 2);

  logic [MCW-1:0] mclk_cnt_q, mclk_cnt_d;
  logic [BCW-1:0] bit_cnt_q,  bit_cnt_d;
  logic           mclk_wrap;

  always_comb begin
    mclk_wrap  = (mclk_cnt_q == MC_LAST);
    mclk_cnt_d = mclk_wrap ? '0 : mclk_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    if (mclk_wrap) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      mclk_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

  // sclk/ws decode straight from reset-cleared flops, so both read 0 during reset.
  // The counter wrap is the sclk falling edge, which is also where ws toggles.
  assign sclk        = (mclk_cnt_q >= MC_HALF);
  assign ws          = (bit_cnt_q >= BIT_HALF);
  assign sclk_fall   = mclk_wrap;
  assign sclk_rise   = (mclk_cnt_q == (MC_HALF - 1'b1));
  assign fb          = mclk_wrap && (bit_cnt_q == BIT_LAST);
  assign bit_cnt     = bit_cnt_q;
  assign bit_cnt_nxt = bit_cnt_d;

endmodule

// File: rtl/i2s_tdm_transceiver.sv
// I2S / left-justified TDM master transceiver: one frame buffered each way.
// Latency: accepted tx frame goes out in the next frame to start; rx frame is presented at the FB ending it.
// Backpressure: tx_ready low while the holding buffer is full; an unread rx frame is overwritten (rx_overrun).
//
// Ports:
//   mclk, reset_n            : sole clock, async active-low reset
//   sclk, ws, sd_tx, sd_rx   : serial bus (master side)
//   tx_data/tx_valid/tx_ready: frame to send, channel 0 in LSBs
//   rx_data/rx_valid/rx_ready: last received frame, channel 0 in LSBs
//   tx_underrun, rx_overrun  : one-mclk error pulses
module i2s_tdm_transceiver
  import i2s_pkg::*;
#(
  parameter int unsigned D_WIDTH         = 24,
  parameter int unsigned SLOT_WIDTH      = 32,
  parameter int unsigned N_CH            = 2,
  parameter int unsigned MCLK_SCLK_RATIO = 4,
  parameter int unsigned MODE            = MODE_I2S
) (
  input  logic                      mclk,
  input  logic                      reset_n,
  output logic                      sclk,
  output logic                      ws,
  output logic                      sd_tx,
  input  logic                      sd_rx,
  input  logic [N_CH*D_WIDTH-1:0]   tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [N_CH*D_WIDTH-1:0]   rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      tx_underrun,
  output logic                      rx_overrun
);

  localparam int unsigned FW    = N_CH * D_WIDTH;
  localparam int unsigned FRAME = frame_len(N_CH, SLOT_WIDTH);
  localparam int unsigned BCW   = $clog2(FRAME);
  localparam int unsigned DLY   = data_dly(MODE);

  logic           sclk_fall, sclk_rise, fb;
  logic [BCW-1:0] bit_cnt, bit_cnt_nxt;

  i2s_clk_gen #(
    .SLOT_WIDTH      (SLOT_WIDTH),
    .N_CH            (N_CH),
    .MCLK_SCLK_RATIO (MCLK_SCLK_RATIO)
  ) u_clk_gen (
    .mclk        (mclk),
    .reset_n     (reset_n),
    .sclk        (sclk),
    .ws          (ws),
    .sclk_fall   (sclk_fall),
    .sclk_rise   (sclk_rise),
    .fb          (fb),
    .bit_cnt     (bit_cnt),
    .bit_cnt_nxt (bit_cnt_nxt)
  );

  // ---------------------------------------------------------------- transmit
  logic [FW-1:0] tx_buf_q,   tx_buf_d;
  logic          tx_full_q,  tx_full_d;
  logic [FW-1:0] tx_frame_q, tx_frame_d;   // frame currently on the wire
  logic          sd_tx_q,    sd_tx_d;
  logic          tx_underrun_q, tx_underrun_d;
  logic          tx_xfer;

  assign tx_xfer = tx_valid && !tx_full_q;

  always_comb begin
    tx_buf_d      = tx_buf_q;
    tx_full_d     = tx_full_q;
    tx_frame_d    = tx_frame_q;
    tx_underrun_d = 1'b0;
    sd_tx_d       = sd_tx_q;

    if (tx_xfer) begin
      tx_buf_d  = tx_data;
      tx_full_d = 1'b1;
    end

    if (fb) begin
      if (tx_full_q) begin
        tx_frame_d = tx_buf_q;
        tx_full_d  = 1'b0;
      end else if (tx_xfer) begin
        // Data arriving on the boundary itself bypasses the buffer so it
        // makes the frame that is starting rather than the one after.
        tx_frame_d = tx_data;
        tx_full_d  = 1'b0;
      end else begin
        tx_frame_d    = '0;
        tx_underrun_d = 1'b1;
      end
    end

    // On each sclk fall, present the bit for the position being entered.
    // Uses tx_frame_d so the MSB at position 0 (no delay) comes from the
    // frame loaded on this same edge.
    if (sclk_fall) begin
      sd_tx_d = 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
        for (int j = 0; j < int'(D_WIDTH); j++) begin
          if (bit_cnt_nxt == BCW'(k * SLOT_WIDTH + DLY + (D_WIDTH - 1 - j))) begin
            sd_tx_d = tx_frame_d[k*D_WIDTH + j];
          end
        end
      end
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      tx_buf_q      <= '0;
      tx_full_q     <= 1'b0;
      tx_frame_q    <= '0;
      sd_tx_q       <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      tx_buf_q      <= tx_buf_d;
      tx_full_q     <= tx_full_d;
      tx_frame_q    <= tx_frame_d;
      sd_tx_q       <= sd_tx_d;
      tx_underrun_q <= tx_underrun_d;
    end
  end

  assign sd_tx       = sd_tx_q;
  assign tx_ready    = !tx_full_q;
  assign tx_underrun = tx_underrun_q;

  // ----------------------------------------------------------------- receive
  logic [FW-1:0] rx_asm_q,  rx_asm_d;      // frame being assembled
  logic [FW-1:0] rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          rx_overrun_q, rx_overrun_d;
  logic          rx_armed_q, rx_armed_d;   // set once a complete frame has been seen

  always_comb begin
    rx_asm_d     = rx_asm_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    rx_overrun_d = 1'b0;
    rx_armed_d   = rx_armed_q;

    if (sclk_rise) begin
      for (int k = 0; k < int'(N_CH); k++) begin
        for (int j = 0; j < int'(D_WIDTH); j++) begin
          if (bit_cnt == BCW'(k * SLOT_WIDTH + DLY + (D_WIDTH - 1 - j))) begin
            rx_asm_d[k*D_WIDTH + j] = sd_rx;
          end
        end
      end
    end

    if (fb) begin
      // The first boundary after reset closes a frame of unknown origin.
      rx_armed_d = 1'b1;
      if (rx_armed_q) begin
        rx_data_d    = rx_asm_q;
        rx_valid_d   = 1'b1;   // wins over a coinciding rx_ready
        rx_overrun_d = rx_valid_q && !rx_ready;
      end
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_asm_q     <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_overrun_q <= 1'b0;
      rx_armed_q   <= 1'b0;
    end else begin
      rx_asm_q     <= rx_asm_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      rx_overrun_q <= rx_overrun_d;
      rx_armed_q   <= rx_armed_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign rx_overrun = rx_overrun_q;

endmodule

// File: doc/i2s_tdm_transceiver.md
I2S_TDM_TRANSCEIVER -- requirements
Module: i2s_tdm_transceiver

Interface
REQ-001 SHALL have parameter D_WIDTH, default 24: audio sample width in bits.
REQ-002 SHALL have parameter SLOT_WIDTH, default 32: sclk periods per channel slot; D_WIDTH <= SLOT_WIDTH-1.
REQ-003 SHALL have parameter N_CH, default 2: channels per frame; even, 2..16.
REQ-004 SHALL have parameter MCLK_SCLK_RATIO, default 4: mclk periods per sclk period; even, >= 2.
REQ-005 SHALL have parameter MODE, default 0: 0 = I2S (1-bit data delay), 1 = left-justified (0-bit delay).
REQ-006 SHALL have port mclk  input  1  sole clock, all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port sclk  output  1  serial bit clock.
REQ-009 SHALL have port ws  output  1  word select / frame sync.
REQ-010 SHALL have port sd_tx  output  1  serial data out.
REQ-011 SHALL have port sd_rx  input  1  serial data in.
REQ-012 SHALL have port tx_data  input  N_CH*D_WIDTH  frame to send, channel 0 in LSBs, signed per channel.
REQ-013 SHALL have ports tx_valid input 1 and tx_ready output 1  transmit handshake.
REQ-014 SHALL have port rx_data  output  N_CH*D_WIDTH  last received frame, channel 0 in LSBs.
REQ-015 SHALL have ports rx_valid output 1 and rx_ready input 1  receive handshake.
REQ-016 SHALL have ports tx_underrun and rx_overrun  output  1 each  one-mclk error pulses.

Function
REQ-017 SHALL count mclk_cnt 0..MCLK_SCLK_RATIO-1; sclk = 0 for the first half of the count, 1 for the second half.
REQ-018 SHALL count bit_cnt 0..FRAME-1, where FRAME = N_CH*SLOT_WIDTH, advancing when mclk_cnt wraps; wraparound to 0 marks the frame-boundary (FB) cycle.
REQ-019 SHALL drive ws = 0 while bit_cnt < FRAME/2 and 1 otherwise; ws changes with sclk falling.
REQ-020 SHALL place bit j of channel k (MSB first) at bit_cnt = k*SLOT_WIDTH + DLY + (D_WIDTH-1-j), where DLY = 1 if MODE=0 and 0 otherwise; all other bit positions carry 0.
REQ-021 SHALL update sd_tx with sclk falling and sample sd_rx on the mclk cycle that raises sclk.
REQ-022 SHALL hold tx_ready = 1 while a one-frame holding buffer is empty; a transfer occurs on a cycle with tx_valid && tx_ready, after which the buffer is full.
REQ-023 SHALL, in the FB cycle, load the shift register from a full buffer and empty it; otherwise it loads all zeros and pulses tx_underrun.
REQ-024 SHALL, when a transfer and FB coincide on an empty buffer, send the accepted data in the frame that is starting.
REQ-025 SHALL, in the FB cycle, copy the assembled receive frame to rx_data and set rx_valid; rx_valid clears on rx_valid && rx_ready.
REQ-026 SHALL, if rx_valid is still 1 at FB without rx_ready, overwrite rx_data, keep rx_valid set and pulse rx_overrun.
REQ-027 SHALL give priority to the set when FB and rx_ready coincide: rx_valid remains 1 and holds the new frame.
REQ-028 SHALL place the first frame after reset on the first FB, whose data is discarded (rx_valid not set) because capture is incomplete.

Reset
REQ-029 SHALL, while reset_n = 0, force the following immediately, regardless of clock: sclk=0, ws=0, sd_tx=0, tx_ready=1, rx_valid=0, rx_data=0, tx_underrun=0, rx_overrun=0, counters=0.
REQ-030 SHALL drop the holding buffer and partial frames on reset mid-frame; operation restarts at bit_cnt=0.

Structure
REQ-031 SHALL take MODE constants (MODE_I2S=0, MODE_LJ=1) and the FRAME/DLY derivation functions from the shared package i2s_pkg.
REQ-032 SHALL implement the sclk/ws/bit_cnt generation as sub-module i2s_clk_gen, which outputs sclk_fall, sclk_rise and fb strobes.

Verification
REQ-033 SHALL check defaults with sd_tx looped to sd_rx: tx ch0=0x123456, ch1=0xABCDEF -> rx_data equal after the second FB, rx_valid=1.
REQ-034 SHALL check defaults with no tx_valid -> sd_tx constantly 0, tx_underrun pulses every 256 mclk.
REQ-035 SHALL check defaults with rx_ready=0 for 2 frames -> rx_overrun at the 2nd FB, rx_data = the 2nd frame.
REQ-036 SHALL check MODE=0 timing: ws falls at FB; the MSB of ch0 appears on sd_tx 4 mclk later; in MODE=1 it appears at FB.
REQ-037 SHALL check MODE=1, N_CH=4, D_WIDTH=16 loopback of 0x0001/0x7FFF/0x8000/0xFFFF -> exact match, ws period 512 mclk.
REQ-038 SHALL check reset_n pulsed low mid-frame -> all outputs reset asynchronously, tx_ready=1, no rx_valid until the 2nd FB.
